axi_write_buffer: RTL and testbench
===================================

Name: axi_write_buffer

Overview:
- Posted-write buffer on the AXI write path, between the MMU top-level AXI master ports (slave side, s_*) and the system interconnect (master side, m_*).
- Single-beat uncached writes are queued in a FIFO and acknowledged immediately, so data stores no longer wait for memory B responses.
- Burst writes (cache line write-back) pass through only after the queue has drained.
- Reads on the AR channel are held back while they overlap a pending buffered write, which preserves read-after-write ordering.

Parameters:
DEPTH, 8, number of posted-write entries; power of two, minimum 2.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
s_awaddr  input  32  write address from MMU
s_awlen  input  8  0 = single beat, otherwise burst
s_awsize  input  3  transfer size
s_awburst  input  2  burst type
s_awvalid  input  1  address valid
s_awready  output  1  address accepted
s_wdata  input  32  write data
s_wstrb  input  4  byte strobes
s_wlast  input  1  last beat
s_wvalid  input  1  data valid
s_wready  output  1  data accepted
s_bresp  output  2  write response to MMU
s_bvalid  output  1  response valid
s_bready  input  1  response accepted
s_araddr  input  32  read address from MMU
s_arlen  input  8  read length
s_arvalid  input  1  read request valid
s_arready  output  1  read request accepted
m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid  output  32/8/3/2/1  write address to memory
m_awready  input  1  memory accepts address
m_wdata, m_wstrb, m_wlast, m_wvalid  output  32/4/1/1  write data to memory
m_wready  input  1  memory accepts data
m_bresp  input  2  memory write response
m_bvalid  input  1  memory response valid
m_bready  output  1  response accepted
m_arvalid  output  1  gated s_arvalid (araddr/arlen/arsize go to memory directly, outside this block)
m_arready  input  1  memory accepts read
bus_err  output  1  sticky write-error flag (see Optional Feature)

Behaviour:
- Reset values: all ready/valid outputs 0, count 0, state IDLE, bus_err 0. Reset mid-operation discards queued and in-flight writes without completing them.
- Top FSM states: IDLE, WAIT_DRAIN, PASS.
- IDLE, single-beat accept:
  - Accepted when s_awvalid && s_wvalid && s_awlen==0 && count<DEPTH && !s_bvalid.
  - s_awready and s_wready are asserted together, in the same cycle.
  - {awaddr, awsize, wdata, wstrb} is pushed.
  - s_bvalid=1 and s_bresp=0 from the next cycle, held until s_bready.
  - No other acceptance occurs while s_bvalid=1.
- Full (count==DEPTH): s_awready=s_wready=0; the request waits, no loss.
- IDLE, burst request:
  - A request with s_awvalid && s_awlen!=0 moves the FSM to WAIT_DRAIN; s_awready=0.
  - WAIT_DRAIN -> PASS when count==0 and the drain engine is idle.
- PASS:
  - Combinational pass-through: s_aw*<->m_aw*, s_w*<->m_w*, m_b*<->s_b*.
  - On the m_bvalid && s_bready handshake the FSM returns to IDLE.
  - No pushes occur during PASS.
- Drain engine (active outside PASS, one outstanding write):
  - When count>0 it presents the head entry on m_aw* (awlen=0, awburst=0) and m_w* (wlast=1) simultaneously.
  - Two flags, aw_done and w_done, record the independent handshakes; each valid drops once its own handshake completes.
  - After both handshakes, m_bready=1 and the engine waits for m_bvalid; the entry pops on the m_bvalid cycle.
  - Next head is presented the cycle after the pop.
  - During drain, s_bvalid is driven only by the posting logic and never reflects m_bvalid.
- Push and pop in the same cycle: count unchanged; head/tail pointers wrap modulo DEPTH.
- Read hazard check:
  - Compared against every valid FIFO entry, including the one in flight.
  - s_arlen==0: compare addr[31:2]. s_arlen!=0: compare addr[31:6] (64-byte line).
  - On a match: m_arvalid=0 and s_arready=0.
  - With no match: m_arvalid=s_arvalid and s_arready=m_arready, combinationally, zero latency.
  - A stalled read releases in the cycle after the matching entry pops.

Optional Feature:
- Macro: WBUF_BRESP_ERR_EN.
- Defined: bus_err is set the cycle after any drained entry completes with m_bresp!=0, and stays set until reset. A PASS-mode bresp is forwarded on s_bresp but never sets bus_err.
- Undefined: bus_err is tied to 0 and drained-entry bresp is ignored.

Test Plan:
- Single write 0x1FC0_0010/0xDEADBEEF, strb 0xF, memory bready=1 -> s_bvalid high 1 cycle after accept, m_awvalid/m_wvalid the cycle after push, count returns to 0 after m_bvalid.
- Nine back-to-back single writes with DEPTH=8 and m_awready=0 -> first 8 accepted; 9th sees s_awready=0 until first pop, then accepted; memory order matches issue order.
- Write 0x1000_0004 queued, then read s_araddr=0x1000_0004 len 0 -> m_arvalid=0 until the entry's m_bvalid, then released next cycle; read to 0x1000_0100 while the buffer is full passes immediately.
- Three writes queued, then burst aw 0x0000_2000 len 15 -> s_awready=0 until all 3 drained, then 16 beats pass through, s_bvalid mirrors m_bvalid, FSM back to IDLE.
- m_wready high 2 cycles before m_awready -> single W beat, single AW, one pop; no duplicated beats.
- rst asserted with 5 entries queued, then m_bresp=2'b10 on a drained write after restart -> count=0 and all valids 0 immediately on rst; bus_err=1 with WBUF_BRESP_ERR_EN defined, 0 without.

Source files
------------

// File: rtl/axi_write_buffer.sv
// Posted-write buffer: single-beat writes are queued and acked at once, bursts pass through once the queue is empty, reads stall on address overlap.
// Latency: push->s_bvalid 1 cycle, push->m_awvalid 1 cycle; PASS/AR paths are combinational. Backpressure: full queue or pending s_bvalid holds s_awready/s_wready low.
// Optional: define WBUF_BRESP_ERR_EN to latch drained-write error responses on bus_err.
module axi_write_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_awaddr,
    input  logic [7:0]  s_awlen,
    input  logic [2:0]  s_awsize,
    input  logic [1:0]  s_awburst,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wlast,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic [7:0]  s_arlen,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] m_awaddr,
    output logic [7:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic        bus_err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_DRAIN, PASS} state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  strb;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head;
    state_e        state_q, state_d;
    logic [PW-1:0] head_q, tail_q, off;
    logic [PW:0]   count_q, count_d;
    logic          bvalid_q, bvalid_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic          push, pop, drain_act, hazard;
    logic          unused_araddr_lsb;

    assign unused_araddr_lsb = ^s_araddr[1:0];
    assign head      = mem_q[head_q];
    assign drain_act = (state_q != PASS) && (count_q != '0);
    assign push      = (state_q == IDLE) && s_awvalid && s_wvalid && (s_awlen == '0)
                       && (count_q < FULL_CNT) && !bvalid_q;
    assign pop       = drain_act && aw_done_q && w_done_q && m_bvalid;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bvalid_d  = bvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE:       if (s_awvalid && s_awlen != '0) state_d = WAIT_DRAIN;
            WAIT_DRAIN: if (count_q == '0 && !bvalid_q) state_d = PASS;
            PASS:       if (m_bvalid && s_bready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push)
            bvalid_d = 1'b1;
        else if (bvalid_q && s_bready)
            bvalid_d = 1'b0;
        // AW and W complete independently; both flags clear together on the pop.
        if (pop) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (drain_act && !aw_done_q && m_awready) aw_done_d = 1'b1;
            if (drain_act && !w_done_q && m_wready)   w_done_d  = 1'b1;
        end
    end

    always_comb begin
        s_awready = push;
        s_wready  = push;
        s_bvalid  = bvalid_q;
        s_bresp   = 2'b00;
        m_awaddr  = head.addr;
        m_awlen   = 8'd0;
        m_awsize  = head.size;
        m_awburst = 2'b00;
        m_awvalid = drain_act && !aw_done_q;
        m_wdata   = head.data;
        m_wstrb   = head.strb;
        m_wlast   = 1'b1;
        m_wvalid  = drain_act && !w_done_q;
        m_bready  = drain_act && aw_done_q && w_done_q;
        if (state_q == PASS) begin
            s_awready = m_awready;
            s_wready  = m_wready;
            s_bvalid  = m_bvalid;
            s_bresp   = m_bresp;
            m_awaddr  = s_awaddr;
            m_awlen   = s_awlen;
            m_awsize  = s_awsize;
            m_awburst = s_awburst;
            m_awvalid = s_awvalid;
            m_wdata   = s_wdata;
            m_wstrb   = s_wstrb;
            m_wlast   = s_wlast;
            m_wvalid  = s_wvalid;
            m_bready  = s_bready;
        end
    end

    // Occupied slots are those within count_q of the head, including the one being drained.
    always_comb begin
        hazard = 1'b0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if ({1'b0, off} < count_q) begin
                if (s_arlen == '0) begin
                    if (mem_q[i].addr[31:2] == s_araddr[31:2]) hazard = 1'b1;
                end else begin
                    if (mem_q[i].addr[31:6] == s_araddr[31:6]) hazard = 1'b1;
                end
            end
        end
    end

    assign m_arvalid = s_arvalid && !hazard;
    assign s_arready = m_arready && !hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            bvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bvalid_q  <= bvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= '{addr: s_awaddr, size: s_awsize, data: s_wdata, strb: s_wstrb};
    end

`ifdef WBUF_BRESP_ERR_EN
    logic bus_err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus_err_q <= 1'b0;
        else if (pop && m_bresp != 2'b00)
            bus_err_q <= 1'b1;
    end
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_buffer.sv
// Directed bench for axi_write_buffer (DEPTH=8); inputs change 1ns after posedge, outputs sampled 2ns after posedge.
module tb_axi_write_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_awaddr = '0;
    logic [7:0]  s_awlen = '0;
    logic [2:0]  s_awsize = '0;
    logic [1:0]  s_awburst = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wlast = 1'b0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = '0;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic        bus_err;

    int checks = 0;
    int failures = 0;

    axi_write_buffer #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        s_awaddr = a; s_awlen = 8'd0; s_awsize = 3'd2; s_awburst = 2'd1;
        s_wdata = d; s_wstrb = 4'hF; s_wlast = 1'b1;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        while (!(s_awready && s_wready) && n < 40) begin
            tick(); #1; n++;
        end
        chk("push_accept", 32'(s_awready & s_wready), 32'd1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic drain_one(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        int n;
        n = 0;
        #1;
        while (!m_awvalid && n < 40) begin
            tick(); #1; n++;
        end
        chk("drain_awaddr", m_awaddr, a);
        chk("drain_wdata", m_wdata, d);
        m_awready = 1'b1; m_wready = 1'b1;
        tick();
        m_awready = 1'b0; m_wready = 1'b0;
        #1;
        chk("drain_bready", 32'(m_bready), 32'd1);
        m_bvalid = 1'b1; m_bresp = resp;
        tick();
        m_bvalid = 1'b0; m_bresp = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_err;
`ifdef WBUF_BRESP_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", 32'(s_awready), 0);
        chk("rst_bvalid", 32'(s_bvalid), 0);
        chk("rst_m_awvalid", 32'(m_awvalid), 0);
        chk("rst_m_wvalid", 32'(m_wvalid), 0);
        chk("rst_m_bready", 32'(m_bready), 0);
        chk("rst_count", 32'(dut.count_q), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        rst = 1'b0;
        tick();

        // Single posted write, acked the cycle after accept
        s_awaddr = 32'h1FC0_0010; s_awlen = 0; s_awsize = 3'd2; s_wdata = 32'hDEAD_BEEF;
        s_wstrb = 4'hF; s_wlast = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        chk("t1_awready", 32'(s_awready), 1);
        chk("t1_wready", 32'(s_wready), 1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        #1;
        chk("t1_bvalid", 32'(s_bvalid), 1);
        chk("t1_bresp", 32'(s_bresp), 0);
        chk("t1_m_awvalid", 32'(m_awvalid), 1);
        chk("t1_m_wvalid", 32'(m_wvalid), 1);
        chk("t1_m_awaddr", m_awaddr, 32'h1FC0_0010);
        chk("t1_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("t1_m_awlen", 32'(m_awlen), 0);
        chk("t1_m_wlast", 32'(m_wlast), 1);
        chk("t1_m_bready_early", 32'(m_bready), 0);
        chk("t1_count", 32'(dut.count_q), 1);
        s_bready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        tick();
        m_awready = 1'b0; m_wready = 1'b0;
        #1;
        chk("t1_bvalid_clr", 32'(s_bvalid), 0);
        chk("t1_awvalid_drop", 32'(m_awvalid), 0);
        chk("t1_m_bready", 32'(m_bready), 1);
        m_bvalid = 1'b1;
        tick();
        m_bvalid = 1'b0;
        #1;
        chk("t1_count_end", 32'(dut.count_q), 0);
        chk("t1_m_bready_end", 32'(m_bready), 0);

        // W accepted two cycles before AW: one beat, one pop
        push_one(32'h0000_3000, 32'h11);
        m_wready = 1'b1;
        tick();
        #1;
        chk("t5_wvalid_drop", 32'(m_wvalid), 0);
        chk("t5_awvalid_hold", 32'(m_awvalid), 1);
        chk("t5_bready_wait", 32'(m_bready), 0);
        tick();
        #1;
        chk("t5_no_dup_w", 32'(m_wvalid), 0);
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0; m_wready = 1'b0;
        #1;
        chk("t5_awvalid_drop", 32'(m_awvalid), 0);
        chk("t5_bready", 32'(m_bready), 1);
        m_bvalid = 1'b1;
        tick();
        m_bvalid = 1'b0;
        #1;
        chk("t5_count", 32'(dut.count_q), 0);

        // Nine writes into an 8-deep queue with memory stalled
        for (int i = 0; i < 8; i++) push_one(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        tick();
        s_awaddr = 32'h120; s_wdata = 32'hA8; s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        chk("t2_full_count", 32'(dut.count_q), 8);
        chk("t2_full_bvalid", 32'(s_bvalid), 0);
        chk("t2_full_awready", 32'(s_awready), 0);
        chk("t2_full_wready", 32'(s_wready), 0);
        drain_one(32'h100, 32'hA0, 2'b00);
        #1;
        chk("t2_ninth_awready", 32'(s_awready), 1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int i = 1; i < 9; i++) drain_one(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b00);
        #1;
        chk("t2_count_end", 32'(dut.count_q), 0);

        // Read-after-write hazard
        push_one(32'h1000_0004, 32'h5);
        m_arready = 1'b1; s_arvalid = 1'b1;
        s_araddr = 32'h1000_0004; s_arlen = 8'd0;
        #1;
        chk("t3_word_block", 32'(m_arvalid), 0);
        chk("t3_word_arready", 32'(s_arready), 0);
        s_araddr = 32'h1000_0008;
        #1;
        chk("t3_other_word", 32'(m_arvalid), 1);
        s_araddr = 32'h1000_0020; s_arlen = 8'd4;
        #1;
        chk("t3_line_block", 32'(m_arvalid), 0);
        s_araddr = 32'h1000_0040;
        #1;
        chk("t3_other_line", 32'(m_arvalid), 1);
        s_araddr = 32'h1000_0004; s_arlen = 8'd0;
        m_awready = 1'b1; m_wready = 1'b1;
        tick();
        m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b1;
        #1;
        chk("t3_inflight_block", 32'(m_arvalid), 0);
        tick();
        m_bvalid = 1'b0;
        #1;
        chk("t3_release", 32'(m_arvalid), 1);
        chk("t3_release_arready", 32'(s_arready), 1);
        s_arvalid = 1'b0;
        for (int i = 0; i < 8; i++) push_one(32'h2000_0000 + 32'(4 * i), 32'hB0 + 32'(i));
        s_arvalid = 1'b1; s_araddr = 32'h1000_0100; s_arlen = 8'd0;
        #1;
        chk("t3_full_pass", 32'(m_arvalid), 1);
        s_araddr = 32'h2000_001C;
        #1;
        chk("t3_full_last_block", 32'(m_arvalid), 0);
        s_araddr = 32'h2000_0010; s_arlen = 8'd8;
        #1;
        chk("t3_full_line_block", 32'(s_arready), 0);
        s_arvalid = 1'b0; m_arready = 1'b0;
        for (int i = 0; i < 8; i++) drain_one(32'h2000_0000 + 32'(4 * i), 32'hB0 + 32'(i), 2'b00);

        // Burst waits for drain, then passes through
        for (int i = 0; i < 3; i++) push_one(32'h3000_0000 + 32'(4 * i), 32'hC0 + 32'(i));
        s_awaddr = 32'h0000_2000; s_awlen = 8'd15; s_awburst = 2'd1; s_awvalid = 1'b1;
        #1;
        chk("t4_burst_hold", 32'(s_awready), 0);
        for (int i = 0; i < 3; i++) begin
            drain_one(32'h3000_0000 + 32'(4 * i), 32'hC0 + 32'(i), 2'b00);
            #1;
            chk("t4_burst_hold_drain", 32'(s_awready), 0);
        end
        tick();
        m_awready = 1'b1;
        #1;
        chk("t4_pass_awready", 32'(s_awready), 1);
        chk("t4_pass_awaddr", m_awaddr, 32'h0000_2000);
        chk("t4_pass_awlen", 32'(m_awlen), 15);
        tick();
        s_awvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            s_wdata = 32'h5500 + 32'(b); s_wlast = (b == 15); s_wvalid = 1'b1;
            #1;
            chk("t4_beat_data", m_wdata, 32'h5500 + 32'(b));
            chk("t4_beat_last", 32'(m_wlast), (b == 15) ? 32'd1 : 32'd0);
            tick();
        end
        s_wvalid = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b1; m_bresp = 2'b10;
        #1;
        chk("t4_pass_bvalid", 32'(s_bvalid), 1);
        chk("t4_pass_bresp", 32'(s_bresp), 2);
        chk("t4_pass_m_bready", 32'(m_bready), 1);
        tick();
        m_bvalid = 1'b0; m_bresp = 2'b00;
        #1;
        chk("t4_bvalid_off", 32'(s_bvalid), 0);
        chk("t4_pass_no_err", 32'(bus_err), 0);
        push_one(32'h4000_0000, 32'hD0);
        chk("t4_idle_again", 32'(dut.count_q), 1);

        // Reset with five queued entries, then an error response
        for (int i = 1; i < 5; i++) push_one(32'h4000_0000 + 32'(4 * i), 32'hD0 + 32'(i));
        #1;
        chk("t6_count5", 32'(dut.count_q), 5);
        rst = 1'b1;
        #1;
        chk("t6_rst_count", 32'(dut.count_q), 0);
        chk("t6_rst_m_awvalid", 32'(m_awvalid), 0);
        chk("t6_rst_m_wvalid", 32'(m_wvalid), 0);
        chk("t6_rst_bvalid", 32'(s_bvalid), 0);
        tick();
        rst = 1'b0;
        tick();
        push_one(32'h5000_0000, 32'hE0);
        drain_one(32'h5000_0000, 32'hE0, 2'b10);
        #1;
        chk("t6_bus_err", 32'(bus_err), 32'(exp_err));
        chk("t6_count_end", 32'(dut.count_q), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
